// File: rtl/mario_dead_pkg.sv
// Shared constants, state encoding and debug view for the dead-Mario animator.
package mario_dead_pkg;

  localparam int SPRITE_W = 21;
  localparam int SPRITE_H = 21;
  localparam int SCREEN_H = 480;
  localparam logic [23:0] KEY_COLOR = 24'h800080;

  typedef enum logic [2:0] {IDLE, FREEZE, RISE, FALL, DONE} state_t;

  typedef struct packed {
    state_t             state;
    logic [9:0]         pos_x;
    logic signed [10:0] pos_y;
    logic signed [4:0]  vel_y;
  } dbg_t;

  // Row-major offset into the 21x21 sprite ROM.
  function automatic logic [8:0] sprite_addr(input logic [4:0] dy, input logic [4:0] dx);
    return 9'(dy) * 9'(SPRITE_W) + 9'(dx);
  endfunction

endpackage

// File: rtl/vs_edge_detect.sv
// Turns the VGA vertical sync into a one-cycle frame tick on its rising edge.
module vs_edge_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic frame_clk_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_clk_q <= 1'b0;
    else          frame_clk_q <= frame_clk;
  end

  assign tick = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/mario_dead_animator.sv
// Dead-Mario death sequence (freeze, hop, fall) plus two-stage sprite pixel fetch.
// Optional blink during the freeze is enabled with `define MARIO_DEAD_BLINK_EN.
module mario_dead_animator
  import mario_dead_pkg::*;
#(
  parameter int FREEZE_FRAMES = 30,
  parameter int JUMP_V        = 6,
  parameter int GRAV_DIV      = 2,
  parameter int MAX_FALL      = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        start,
  input  logic [9:0]  start_x,
  input  logic [9:0]  start_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [8:0]  read_address,
  input  logic [23:0] rom_color,
  output logic        is_dead_mario,
  output logic [23:0] dead_color,
  output logic        busy,
  output logic        done,
  output dbg_t        dbg
);

  localparam int FC_W = $clog2(FREEZE_FRAMES + 1);
  localparam int GC_W = $clog2(GRAV_DIV + 1);
  localparam logic [FC_W-1:0]  FREEZE_LAST   = FC_W'(FREEZE_FRAMES - 1);
  localparam logic [GC_W-1:0]  GRAV_LAST     = GC_W'(GRAV_DIV - 1);
  localparam logic signed [4:0]  LAUNCH_V    = 5'(-JUMP_V);
  localparam logic signed [4:0]  MAX_V       = 5'(MAX_FALL);
  localparam logic signed [10:0] SCREEN_BOT  = 11'(SCREEN_H);
  localparam logic signed [11:0] SPR_W_S     = 12'(SPRITE_W);
  localparam logic signed [11:0] SPR_H_S     = 12'(SPRITE_H);

  logic tick;

  vs_edge_detect u_vs_edge_detect (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  state_t             state, state_next;
  logic [9:0]         pos_x, pos_x_next;
  logic signed [10:0] pos_y, pos_y_next, pos_step;
  logic signed [4:0]  vel_y, vel_y_next, vel_step;
  logic [FC_W-1:0]    freeze_cnt, freeze_cnt_next;
  logic [GC_W-1:0]    grav_cnt, grav_cnt_next, grav_step;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      pos_x      <= '0;
      pos_y      <= '0;
      vel_y      <= '0;
      freeze_cnt <= '0;
      grav_cnt   <= '0;
    end else begin
      state      <= state_next;
      pos_x      <= pos_x_next;
      pos_y      <= pos_y_next;
      vel_y      <= vel_y_next;
      freeze_cnt <= freeze_cnt_next;
      grav_cnt   <= grav_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    pos_x_next      = pos_x;
    pos_y_next      = pos_y;
    vel_y_next      = vel_y;
    freeze_cnt_next = freeze_cnt;
    grav_cnt_next   = grav_cnt;

    // One physics step: move with the old velocity, then apply gravity every GRAV_DIV frames.
    pos_step = pos_y + {{6{vel_y[4]}}, vel_y};
    if (grav_cnt == GRAV_LAST) begin
      vel_step  = (vel_y >= MAX_V) ? MAX_V : vel_y + 5'sd1;
      grav_step = '0;
    end else begin
      vel_step  = vel_y;
      grav_step = grav_cnt + 1'b1;
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next      = FREEZE;
          pos_x_next      = start_x;
          pos_y_next      = {1'b0, start_y};
          freeze_cnt_next = '0;
        end
      end
      FREEZE: begin
        if (tick) begin
          freeze_cnt_next = freeze_cnt + 1'b1;
          if (freeze_cnt == FREEZE_LAST) begin
            state_next    = RISE;
            vel_y_next    = LAUNCH_V;
            grav_cnt_next = '0;
          end
        end
      end
      RISE, FALL: begin
        if (tick) begin
          pos_y_next    = pos_step;
          vel_y_next    = vel_step;
          grav_cnt_next = grav_step;
          if (state == RISE) begin
            if (!vel_step[4]) state_next = FALL;
          end else if (pos_step >= SCREEN_BOT) begin
            state_next = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == FREEZE) || (state == RISE) || (state == FALL);
  assign done = (state == DONE);
  assign dbg  = '{state: state, pos_x: pos_x, pos_y: pos_y, vel_y: vel_y};

  // Stage 1: locate the pixel inside the sprite box and form the ROM address.
  logic signed [11:0] dx, dy;
  logic               in_box, blank;
  logic               in_box_d, blank_d;

  always_comb begin
    dx     = $signed({2'b00, DrawX}) - $signed({2'b00, pos_x});
    dy     = $signed({2'b00, DrawY}) - $signed({pos_y[10], pos_y});
    in_box = (state != IDLE) && (dx >= 12'sd0) && (dx < SPR_W_S) &&
             (dy >= 12'sd0) && (dy < SPR_H_S);
`ifdef MARIO_DEAD_BLINK_EN
    blank  = (state == FREEZE) && freeze_cnt[2];
`else
    blank  = 1'b0;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      in_box_d     <= 1'b0;
      blank_d      <= 1'b0;
    end else begin
      read_address <= in_box ? sprite_addr(dy[4:0], dx[4:0]) : '0;
      in_box_d     <= in_box;
      blank_d      <= blank;
    end
  end

  // Stage 2: ROM colour comes back for the registered address; drop the key colour.
  logic visible;
  assign visible = in_box_d && !blank_d && (rom_color != KEY_COLOR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      is_dead_mario <= 1'b0;
      dead_color    <= '0;
    end else begin
      is_dead_mario <= visible;
      dead_color    <= visible ? rom_color : '0;
    end
  end

endmodule

// File: tb/tb_mario_dead_animator.sv
// Self-checking bench: directed death-arc and pixel cases plus randomized runs vs. a frame-level model.
module tb_mario_dead_animator;
  import mario_dead_pkg::*;

  localparam int FREEZE_FRAMES = 30;
  localparam int JUMP_V        = 6;
  localparam int GRAV_DIV      = 2;
  localparam int MAX_FALL      = 8;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_x = '0, start_y = '0, DrawX = '0, DrawY = '0;
  logic [8:0]  read_address;
  logic [23:0] rom_color, dead_color;
  logic        is_dead_mario, busy, done;
  dbg_t        dbg;

  int n_checks = 0;
  int n_errors = 0;
  int rom_mode = 0;
  bit cmp_en = 1'b0;
  bit rand_pix = 1'b0;

  mario_dead_animator #(
    .FREEZE_FRAMES(FREEZE_FRAMES), .JUMP_V(JUMP_V), .GRAV_DIV(GRAV_DIV), .MAX_FALL(MAX_FALL)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start(start),
    .start_x(start_x), .start_y(start_y), .DrawX(DrawX), .DrawY(DrawY),
    .read_address(read_address), .rom_color(rom_color), .is_dead_mario(is_dead_mario),
    .dead_color(dead_color), .busy(busy), .done(done), .dbg(dbg)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- sprite ROM stand-in ----------------
  function automatic logic [23:0] rom_of(input int a);
    case (rom_mode)
      1:       return 24'hF83800;
      2:       return KEY_COLOR;
      default: return (a % 5 == 2) ? KEY_COLOR : {3'b000, 9'(a), 3'b101, 9'(a)};
    endcase
  endfunction

  always_comb begin
    case (rom_mode)
      1:       rom_color = 24'hF83800;
      2:       rom_color = KEY_COLOR;
      default: rom_color = (int'(read_address) % 5 == 2) ? KEY_COLOR
                           : {3'b000, read_address, 3'b101, read_address};
    endcase
  end

  // ---------------- behavioural model (one step per clock) ----------------
  state_t m_state = IDLE;
  int m_px = 0, m_py = 0, m_vel = 0, m_fcnt = 0, m_n = 0, m_addr = 0;
  bit m_prev = 0, m_inb = 0, m_blank = 0;
  logic [24:0] exp_q[$];

  always @(posedge Clk or negedge Reset_n) begin
    int dx, dy;
    bit is_v, tick;
    logic [23:0] rc;
    if (!Reset_n) begin
      m_state = IDLE; m_px = 0; m_py = 0; m_vel = 0; m_fcnt = 0; m_n = 0;
      m_addr = 0; m_prev = 0; m_inb = 0; m_blank = 0;
      exp_q.delete();
    end else begin
      tick = frame_clk && !m_prev;
      m_prev = frame_clk;
      rc   = rom_of(m_addr);
      is_v = m_inb && !m_blank && (rc != KEY_COLOR);
      exp_q.push_back({is_v, is_v ? rc : 24'h0});
      dx = int'(DrawX) - m_px;
      dy = int'(DrawY) - m_py;
      m_inb  = (m_state != IDLE) && dx >= 0 && dx < SPRITE_W && dy >= 0 && dy < SPRITE_H;
      m_addr = m_inb ? dy * SPRITE_W + dx : 0;
`ifdef MARIO_DEAD_BLINK_EN
      m_blank = (m_state == FREEZE) && ((m_fcnt / 4) % 2 == 1);
`else
      m_blank = 0;
`endif
      if ((m_state == IDLE || m_state == DONE) && start) begin
        m_state = FREEZE; m_px = int'(start_x); m_py = int'(start_y); m_fcnt = 0;
      end else if (tick) begin
        if (m_state == FREEZE) begin
          m_fcnt++;
          if (m_fcnt == FREEZE_FRAMES) begin
            m_state = RISE; m_n = 0; m_vel = -JUMP_V;
          end
        end else if (m_state == RISE || m_state == FALL) begin
          // Velocity after n frames of flight: -JUMP_V + n/GRAV_DIV, capped.
          m_py += m_vel;
          m_n++;
          m_vel = -JUMP_V + m_n / GRAV_DIV;
          if (m_vel > MAX_FALL) m_vel = MAX_FALL;
          if (m_state == RISE) begin
            if (m_vel >= 0) m_state = FALL;
          end else if (m_py >= SCREEN_H) begin
            m_state = DONE;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    logic [24:0] e;
    if (cmp_en) begin
      check("busy", int'(busy), (m_state == FREEZE || m_state == RISE || m_state == FALL) ? 1 : 0);
      check("done", int'(done), (m_state == DONE) ? 1 : 0);
      check("state", int'(dbg.state), int'(m_state));
      check("pos_x", int'(dbg.pos_x), m_px);
      check("pos_y", int'(dbg.pos_y), m_py);
      if (m_state == RISE || m_state == FALL) check("vel_y", int'(dbg.vel_y), m_vel);
      check("read_address", int'(read_address), m_addr);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 25'h0;
      check("is_dead_mario", int'(is_dead_mario), int'(e[24]));
      check("dead_color", int'(dead_color), int'(e[23:0]));
    end
  end

  // ---------------- drivers ----------------
  function automatic logic [9:0] clamp10(input int v);
    if (v < 0) return 10'd0;
    if (v > 1023) return 10'd1023;
    return 10'(v);
  endfunction

  always @(posedge Clk) begin
    if (rand_pix) begin
      #2;
      if ($urandom_range(0, 5) == 0) DrawX = 10'($urandom_range(0, 1023));
      else DrawX = clamp10(m_px + int'($urandom_range(0, 26)) - 3);
      DrawY = clamp10(m_py + int'($urandom_range(0, 26)) - 3);
      rom_mode = ($urandom_range(0, 9) == 0) ? 1 : 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    cyc(1);
    frame_clk = 1'b0;
    cyc(2 + int'($urandom_range(0, 2)));
  endtask

  task automatic kick(input int x, input int y);
    start_x = 10'(x);
    start_y = 10'(y);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int max_frames);
    int f;
    for (f = 0; f < max_frames && !done; f++) frame();
    if (!done) check({tag, "_timeout"}, 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int rise_y[12] = '{194, 188, 183, 178, 174, 170, 167, 164, 162, 160, 159, 158};
    int peak, f;

    cyc(3);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg.state), int'(IDLE));
    check("rst_addr", int'(read_address), 0);
    check("rst_is_dead", int'(is_dead_mario), 0);
    check("rst_color", int'(dead_color), 0);
    cmp_en = 1'b1;
    Reset_n = 1'b1;
    cyc(2);

    // Freeze at (100,200), pixel pipeline checks while frozen.
    kick(100, 200);
    check("start_state", int'(dbg.state), int'(FREEZE));
    DrawX = 10'd110; DrawY = 10'd205; rom_mode = 1;
    cyc(1);
    check("px_addr", int'(read_address), 115);
    cyc(1);
    check("px_opaque_is", int'(is_dead_mario), 1);
    check("px_opaque_color", int'(dead_color), 24'hF83800);
    rom_mode = 2;
    cyc(1);
    check("px_key_is", int'(is_dead_mario), 0);
    check("px_key_color", int'(dead_color), 0);
    DrawX = 10'd121;
    cyc(1);
    check("px_dx21_addr", int'(read_address), 0);
    cyc(1);
    check("px_dx21_is", int'(is_dead_mario), 0);
    DrawX = 10'd110; rom_mode = 1;
    cyc(2);

    for (int k = 0; k < FREEZE_FRAMES; k++) begin
      if (k < 12) begin
`ifdef MARIO_DEAD_BLINK_EN
        check("blink_is", int'(is_dead_mario), ((k / 4) % 2 == 0) ? 1 : 0);
`else
        check("solid_is", int'(is_dead_mario), 1);
`endif
      end
      frame();
      check("freeze_pos_y", int'(dbg.pos_y), 200);
      check("freeze_busy", int'(busy), 1);
      check("freeze_state", int'(dbg.state), (k < FREEZE_FRAMES - 1) ? int'(FREEZE) : int'(RISE));
    end
    rom_mode = 0;

    // Hop arc with default gravity.
    for (int i = 0; i < 12; i++) begin
      frame();
      check("rise_pos_y", int'(dbg.pos_y), rise_y[i]);
      check("rise_state", int'(dbg.state), (i == 11) ? int'(FALL) : int'(RISE));
    end
    check("fall_entry_vel", int'(dbg.vel_y), 0);

    // Fall to the bottom; a start while busy must be ignored.
    peak = 0;
    for (f = 0; f < 200 && !done; f++) begin
      frame();
      if (int'(dbg.vel_y) > peak) peak = int'(dbg.vel_y);
      if (f == 3) begin
        kick(300, 100);
        check("start_ignored_x", int'(dbg.pos_x), 100);
      end
    end
    if (!done) check("fall_timeout", 0, 1);
    check("done_flag", int'(done), 1);
    check("done_busy", int'(busy), 0);
    check("done_offscreen", (int'(dbg.pos_y) >= SCREEN_H) ? 1 : 0, 1);
    check("peak_vel", peak, MAX_FALL);

    // Start and frame tick in the same DONE cycle: tick must not count.
    frame_clk = 1'b1; start_x = 10'd50; start_y = 10'd60; start = 1'b1;
    cyc(1);
    frame_clk = 1'b0; start = 1'b0;
    cyc(2);
    check("restart_state", int'(dbg.state), int'(FREEZE));
    check("restart_done", int'(done), 0);
    repeat (FREEZE_FRAMES - 1) frame();
    check("restart_still_freeze", int'(dbg.state), int'(FREEZE));
    frame();
    check("restart_rise", int'(dbg.state), int'(RISE));
    run_to_done("restart", 200);

    // Randomized sequences against the model.
    rand_pix = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cyc(int'($urandom_range(1, 4)));
      kick(int'($urandom_range(0, 620)), int'($urandom_range(0, 470)));
      run_to_done("rand", 250);
    end

    // Reset in the middle of the fall.
    kick(int'($urandom_range(0, 620)), int'($urandom_range(100, 300)));
    for (f = 0; f < 100 && dbg.state != FALL; f++) frame();
    if (dbg.state != FALL) check("reach_fall_timeout", 0, 1);
    frame();
    frame();
    Reset_n = 1'b0;
    #1;
    check("midrst_state", int'(dbg.state), int'(IDLE));
    check("midrst_busy", int'(busy), 0);
    check("midrst_addr", int'(read_address), 0);
    check("midrst_is_dead", int'(is_dead_mario), 0);
    check("midrst_color", int'(dead_color), 0);
    cyc(1);
    Reset_n = 1'b1;
    cyc(1);
    kick(200, 150);
    check("post_rst_busy", int'(busy), 1);
    check("post_rst_state", int'(dbg.state), int'(FREEZE));
    cyc(5);

    rand_pix = 1'b0;
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
